// File: rtl/pe_mac_param.sv
`default_nettype none
// ============================================================================
// Module   : pe_mac_param
// Purpose  : Parametrised dot-product processing element. Computes the sum
//            of N_TERMS weight*activation products, LANES products per clock,
//            on top of an initial value (bias or previous result), then
//            saturates to ACC_W bits. Signed or unsigned arithmetic.
// Ports    : clk, rst          - clock / synchronous active-high reset
//            start             - request an operation (accepted in IDLE only)
//            signed_mode       - 1 = two's complement operands, 0 = unsigned
//            acc_en            - 1 = start from mac_out, 0 = start from bias
//            bias              - initial value when acc_en = 0
//            weights_flat      - N_TERMS packed weights, element i at i*DATA_W
//            inputs_flat       - N_TERMS packed activations, same packing
//            mac_out, ovf      - saturated result and clamp flag (held)
//            busy, done        - operation in flight / one-cycle completion
// Revision : 1.0 - initial release
// ============================================================================
module pe_mac_param #(
    parameter int N_TERMS = 27,
    parameter int DATA_W  = 8,
    parameter int LANES   = 9,
    parameter int ACC_W   = 24
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic                      signed_mode,
    input  logic                      acc_en,
    input  logic [ACC_W-1:0]          bias,
    input  logic [N_TERMS*DATA_W-1:0] weights_flat,
    input  logic [N_TERMS*DATA_W-1:0] inputs_flat,
    output logic [ACC_W-1:0]          mac_out,
    output logic                      ovf,
    output logic                      busy,
    output logic                      done
);

    localparam int c_k       = (N_TERMS + LANES - 1) / LANES;
    localparam int c_cw      = (c_k > 1) ? $clog2(c_k) : 1;
    localparam int c_aw      = ACC_W + 2*DATA_W + $clog2(N_TERMS) + 2;
    localparam int c_chunk_w = LANES * DATA_W;
    localparam int c_pad_w   = c_k * c_chunk_w;
    localparam int c_pw      = 2*DATA_W + 2;

    // Saturation bounds expressed at accumulator width.
    localparam logic signed [c_aw-1:0] c_smax = {{(c_aw-ACC_W+1){1'b0}}, {(ACC_W-1){1'b1}}};
    localparam logic signed [c_aw-1:0] c_smin = {{(c_aw-ACC_W+1){1'b1}}, {(ACC_W-1){1'b0}}};
    localparam logic signed [c_aw-1:0] c_umax = {{(c_aw-ACC_W){1'b0}}, {ACC_W{1'b1}}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MAC  = 2'd1,
        S_FIN  = 2'd2
    } state_t;

    state_t                   r_state;
    state_t                   w_state_next;
    logic [c_cw-1:0]          r_cnt;
    logic                     r_sm;
    logic [c_pad_w-1:0]       r_wts;
    logic [c_pad_w-1:0]       r_ins;
    logic signed [c_aw-1:0]   r_acc;
    logic [ACC_W-1:0]         r_mac_out;
    logic                     r_ovf;
    logic                     r_done;

    logic [ACC_W-1:0]         w_init_src;
    logic signed [c_aw-1:0]   w_init;
    logic signed [DATA_W:0]   w_a;
    logic signed [DATA_W:0]   w_b;
    logic signed [c_pw-1:0]   w_prod;
    logic signed [c_aw-1:0]   w_sum;
    logic signed [c_aw-1:0]   w_sat;
    logic                     w_clamped;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_state_next = S_MAC;
            S_MAC:   if (r_cnt == c_cw'(c_k - 1)) w_state_next = S_FIN;
            S_FIN:   w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // Initial accumulator value, extended according to the requested mode.
    always_comb begin
        w_init_src = acc_en ? r_mac_out : bias;
        w_init     = {{(c_aw-ACC_W){signed_mode & w_init_src[ACC_W-1]}}, w_init_src};
    end

    // Sum of the current chunk. Operand registers shift down one chunk per
    // MAC cycle, so the live chunk is always the low LANES elements. The
    // zero padding beyond N_TERMS makes unused lanes contribute nothing.
    // Each operand gets one extra bit: sign in signed mode, zero otherwise,
    // so a single signed multiplier covers both modes.
    always_comb begin
        w_sum  = '0;
        w_a    = '0;
        w_b    = '0;
        w_prod = '0;
        for (int l = 0; l < LANES; l++) begin
            w_a    = {r_sm & r_wts[l*DATA_W + DATA_W-1], r_wts[l*DATA_W +: DATA_W]};
            w_b    = {r_sm & r_ins[l*DATA_W + DATA_W-1], r_ins[l*DATA_W +: DATA_W]};
            w_prod = w_a * w_b;
            w_sum  = w_sum + {{(c_aw-c_pw){w_prod[c_pw-1]}}, w_prod};
        end
    end

    // Output saturation.
    always_comb begin
        w_sat     = r_acc;
        w_clamped = 1'b0;
        if (r_sm) begin
            if (r_acc > c_smax) begin
                w_sat     = c_smax;
                w_clamped = 1'b1;
            end else if (r_acc < c_smin) begin
                w_sat     = c_smin;
                w_clamped = 1'b1;
            end
        end else begin
            if (r_acc[c_aw-1]) begin
                w_sat     = '0;
                w_clamped = 1'b1;
            end else if (r_acc > c_umax) begin
                w_sat     = c_umax;
                w_clamped = 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt     <= '0;
            r_sm      <= 1'b0;
            r_wts     <= '0;
            r_ins     <= '0;
            r_acc     <= '0;
            r_mac_out <= '0;
            r_ovf     <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_wts <= c_pad_w'(weights_flat);
                        r_ins <= c_pad_w'(inputs_flat);
                        r_sm  <= signed_mode;
                        r_acc <= w_init;
                        r_cnt <= '0;
                    end
                end
                S_MAC: begin
                    r_acc <= r_acc + w_sum;
                    r_wts <= r_wts >> c_chunk_w;
                    r_ins <= r_ins >> c_chunk_w;
                    r_cnt <= r_cnt + 1'b1;
                end
                S_FIN: begin
                    r_mac_out <= w_sat[ACC_W-1:0];
                    r_ovf     <= w_clamped;
                    r_done    <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign mac_out = r_mac_out;
    assign ovf     = r_ovf;
    assign done    = r_done;
    assign busy    = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_pe_mac_param.sv
`default_nettype none
// ============================================================================
// Module   : tb_pe_mac_param
// Purpose  : Directed self-checking bench for pe_mac_param. Instance u_dut
//            uses the default geometry (27 terms, 9 lanes); instance u_dut_b
//            uses 10 terms on 4 lanes to exercise padded lanes.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pe_mac_param;

    localparam int C_N  = 27;
    localparam int C_NB = 10;

    logic              clk = 1'b0;
    logic              rst;
    logic              start, signed_mode, acc_en;
    logic [23:0]       bias;
    logic [C_N*8-1:0]  wf, xf;
    logic [23:0]       mac_out;
    logic              ovf, busy, done;

    logic              start_b, signed_mode_b, acc_en_b;
    logic [23:0]       bias_b;
    logic [C_NB*8-1:0] wf_b, xf_b;
    logic [23:0]       mac_out_b;
    logic              ovf_b, busy_b, done_b;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    pe_mac_param u_dut (
        .clk(clk), .rst(rst), .start(start), .signed_mode(signed_mode),
        .acc_en(acc_en), .bias(bias), .weights_flat(wf), .inputs_flat(xf),
        .mac_out(mac_out), .ovf(ovf), .busy(busy), .done(done)
    );

    pe_mac_param #(.N_TERMS(C_NB), .DATA_W(8), .LANES(4), .ACC_W(24)) u_dut_b (
        .clk(clk), .rst(rst), .start(start_b), .signed_mode(signed_mode_b),
        .acc_en(acc_en_b), .bias(bias_b), .weights_flat(wf_b), .inputs_flat(xf_b),
        .mac_out(mac_out_b), .ovf(ovf_b), .busy(busy_b), .done(done_b)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [C_N*8-1:0] rep(input logic [7:0] v);
        logic [C_N*8-1:0] r;
        for (int i = 0; i < C_N; i++) r[i*8 +: 8] = v;
        return r;
    endfunction

    // Called at a negedge; start is seen by the following posedge.
    task automatic go(input logic sm, input logic ae, input logic [23:0] b,
                      input logic [C_N*8-1:0] w, input logic [C_N*8-1:0] x);
        signed_mode = sm;
        acc_en      = ae;
        bias        = b;
        wf          = w;
        xf          = x;
        start       = 1'b1;
        @(negedge clk);
        start       = 1'b0;
    endtask

    // Entered at the negedge right after the accepting edge. lat counts
    // clock edges after acceptance until done is observed.
    task automatic wait_done(output int lat, output int bcnt);
        lat  = 0;
        bcnt = 0;
        while (!done && lat < 20) begin
            if (busy) bcnt++;
            @(negedge clk);
            lat++;
        end
        check("done_seen", {63'd0, done}, 64'd1);
        check("busy_with_done", {63'd0, busy}, 64'd0);
    endtask

    initial begin
        int lat, bcnt, extra;
        rst = 1'b1; start = 1'b0; signed_mode = 1'b0; acc_en = 1'b0;
        bias = '0; wf = '0; xf = '0;
        start_b = 1'b0; signed_mode_b = 1'b0; acc_en_b = 1'b0;
        bias_b = '0; wf_b = '0; xf_b = '0;
        repeat (3) @(negedge clk);
        check("rst_mac_out", {40'd0, mac_out}, 64'd0);
        check("rst_ovf",  {63'd0, ovf},  64'd0);
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_done", {63'd0, done}, 64'd0);
        rst = 1'b0;

        // Basic unsigned dot product: 27 * 1 * 2
        @(negedge clk);
        go(1'b0, 1'b0, 24'd0, rep(8'd1), rep(8'd2));
        wait_done(lat, bcnt);
        check("lat_basic", 64'(lat), 64'd4);
        check("busy_cycles", 64'(bcnt), 64'd4);
        check("mac_basic", {40'd0, mac_out}, 64'd54);
        check("ovf_basic", {63'd0, ovf}, 64'd0);
        @(negedge clk);
        check("done_one_cycle", {63'd0, done}, 64'd0);
        check("mac_held", {40'd0, mac_out}, 64'd54);

        // Signed: 27 * (-1) * 127 = -3429
        go(1'b1, 1'b0, 24'd0, rep(8'hFF), rep(8'h7F));
        wait_done(lat, bcnt);
        check("mac_signed", {40'd0, mac_out}, 64'hFFF29B);
        check("ovf_signed", {63'd0, ovf}, 64'd0);
        @(negedge clk);
        // Unsigned: 27 * 255 * 127 = 874395
        go(1'b0, 1'b0, 24'd0, rep(8'hFF), rep(8'h7F));
        wait_done(lat, bcnt);
        check("mac_unsigned", {40'd0, mac_out}, 64'h0D579B);

        // Accumulation chain, second start issued in the done cycle
        @(negedge clk);
        go(1'b0, 1'b0, 24'd0, rep(8'd1), rep(8'd2));
        wait_done(lat, bcnt);
        check("acc_first", {40'd0, mac_out}, 64'd54);
        go(1'b0, 1'b1, 24'd0, rep(8'd1), rep(8'd2));
        wait_done(lat, bcnt);
        check("acc_second", {40'd0, mac_out}, 64'd108);
        @(negedge clk);
        go(1'b0, 1'b0, 24'd10, rep(8'd1), rep(8'd2));
        wait_done(lat, bcnt);
        check("acc_bias10", {40'd0, mac_out}, 64'd64);

        // Saturation cases
        @(negedge clk);
        go(1'b1, 1'b0, 24'h7FFFFF, rep(8'd1), rep(8'd1));
        wait_done(lat, bcnt);
        check("sat_spos", {40'd0, mac_out}, 64'h7FFFFF);
        check("sat_spos_ovf", {63'd0, ovf}, 64'd1);
        @(negedge clk);
        go(1'b0, 1'b0, 24'hFFFFFF, rep(8'd1), rep(8'd1));
        wait_done(lat, bcnt);
        check("sat_upos", {40'd0, mac_out}, 64'hFFFFFF);
        check("sat_upos_ovf", {63'd0, ovf}, 64'd1);
        @(negedge clk);
        go(1'b1, 1'b0, 24'h800000, rep(8'hFF), rep(8'd1));
        wait_done(lat, bcnt);
        check("sat_sneg", {40'd0, mac_out}, 64'h800000);
        check("sat_sneg_ovf", {63'd0, ovf}, 64'd1);

        // Start re-pulsed one cycle after acceptance must be ignored
        @(negedge clk);
        go(1'b0, 1'b0, 24'd0, rep(8'd1), rep(8'd2));
        acc_en = 1'b1; bias = 24'd100; wf = rep(8'd3); start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(lat, bcnt);
        check("ignore_start_mac", {40'd0, mac_out}, 64'd54);
        check("ovf_cleared", {63'd0, ovf}, 64'd0);
        extra = 0;
        repeat (8) begin
            @(negedge clk);
            if (done) extra++;
        end
        check("ignore_start_single_done", 64'(extra), 64'd0);

        // Reset mid-operation abandons it
        go(1'b0, 1'b0, 24'd0, rep(8'd1), rep(8'd2));
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_busy", {63'd0, busy}, 64'd0);
        check("midrst_done", {63'd0, done}, 64'd0);
        check("midrst_mac",  {40'd0, mac_out}, 64'd0);
        rst = 1'b0;
        extra = 0;
        repeat (6) begin
            @(negedge clk);
            if (done) extra++;
        end
        check("midrst_no_done", 64'(extra), 64'd0);
        go(1'b0, 1'b0, 24'd0, rep(8'd1), rep(8'd2));
        wait_done(lat, bcnt);
        check("post_rst_lat", 64'(lat), 64'd4);
        check("post_rst_mac", {40'd0, mac_out}, 64'd54);

        // 10 terms on 4 lanes: weights 1..10, inputs 1 -> 55, K = 3
        @(negedge clk);
        for (int i = 0; i < C_NB; i++) begin
            wf_b[i*8 +: 8] = 8'(i + 1);
            xf_b[i*8 +: 8] = 8'd1;
        end
        signed_mode_b = 1'b0; acc_en_b = 1'b0; bias_b = '0; start_b = 1'b1;
        @(negedge clk);
        start_b = 1'b0;
        lat = 0;
        while (!done_b && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check("b_done_seen", {63'd0, done_b}, 64'd1);
        check("b_lat", 64'(lat), 64'd4);
        check("b_mac", {40'd0, mac_out_b}, 64'd55);
        check("b_ovf", {63'd0, ovf_b}, 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
